dmem_io_bridge: RTL and testbench

- Sits directly downstream of the single-cycle CPU's data port: takes the CPU data address, write data and write enable, and returns read data in the same cycle.
- Splits accesses between the external data memory and a small memory-mapped IO window.
- The IO window holds an LED register, a UART transmitter with a 4-entry FIFO, and an optional cycle counter.

---
 rtl/dmem_io_bridge_pkg.sv | 33 +++
 rtl/dmem_io_bridge_uart_tx.sv | 174 +++++++++++++++++
 rtl/dmem_io_bridge.sv | 158 +++++++++++++++
 tb/tb_dmem_io_bridge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_bridge_pkg.sv
// ---------------------------------------------------------------------------
// dmem_io_bridge_pkg
// Shared definitions for the data-memory / IO bridge:
//   - IO register offsets inside the 256-byte IO window
//   - UART transmitter FSM state encoding
//   - bit positions of the UART_STATUS register
// ---------------------------------------------------------------------------
package dmem_io_bridge_pkg;

  // Register offsets, compared against cpuAddr[7:0]
  localparam logic [7:0] IO_LED_OFS       = 8'h00;
  localparam logic [7:0] IO_UART_DATA_OFS = 8'h04;
  localparam logic [7:0] IO_UART_STAT_OFS = 8'h08;
  localparam logic [7:0] IO_CYCLE_OFS     = 8'h0C;

  // UART serializer states; anything other than IDLE counts as busy
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // UART_STATUS layout
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 3;
  localparam int STAT_W         = STAT_COUNT_LSB + STAT_COUNT_W;

endpackage

// File: rtl/dmem_io_bridge_uart_tx.sv
// ---------------------------------------------------------------------------
// dmem_io_bridge_uart_tx
// Byte FIFO plus 8N1 serializer for the bridge's UART.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, pushData  enqueue request and byte; dropped when full
//   full, empty     FIFO flags from registered state
//   count           FIFO occupancy (0..FIFO_DEPTH)
//   busy            serializer is not IDLE
//   tx              registered serial line, idles high
//
// Push semantics: a push is accepted iff full==0 at the start of the cycle,
// so a push into a full FIFO is lost even when a pop happens in that cycle.
// Frame: START (0), 8 data bits LSB first, STOP (1), CLKS_PER_BIT clocks each.
// ---------------------------------------------------------------------------
module dmem_io_bridge_uart_tx
  import dmem_io_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [7:0]                   pushData,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         busy,
  output logic                         tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  // FIFO storage and pointers; pointers wrap naturally since depth is 2^n
  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop;
  logic [7:0]        fifo_head;

  // Serializer
  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign push_ok   = push & ~full;
  assign fifo_head = fifo_mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx        = tx_q;

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage carries no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= pushData;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes
          // have no idle gap on the line
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: tx is registered, so it is computed from the next state and
  // the line changes in the same edge the FSM moves
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != IDLE);
  end

endmodule

// File: rtl/dmem_io_bridge.sv
// ---------------------------------------------------------------------------
// dmem_io_bridge
// Sits on the data port of a single-cycle CPU. Accesses whose upper address
// bits match IO_BASE go to a 256-byte IO window; everything else passes
// straight through to the external data memory. Reads return in the same
// cycle.
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   cpuAddr, cpuWrData, cpuWrEnable       CPU data port request
//   cpuRdData                             combinational read data to the CPU
//   memAddr, memWrData, memWrEnable       data memory request (pass-through)
//   memRdData                             data memory read data
//   ledOut                                LED register
//   uartTx                                UART serial line, idle high
//
// IO map (offset = cpuAddr[7:0]):
//   0x00 LED          RW, low byte of the store
//   0x04 UART_DATA    W pushes a byte, reads 0
//   0x08 UART_STATUS  R {count[6:4], overflow, busy, empty, full}; a write
//                     clears the sticky overflow bit
//   0x0C CYCLE        free-running 32-bit counter, a write zeroes it; only
//                     present when DMEM_IO_BRIDGE_CYCLE_COUNTER_EN is
//                     defined, otherwise reads 0
// ---------------------------------------------------------------------------
module dmem_io_bridge
  import dmem_io_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = 14'h3F00,
  parameter int                    CLKS_PER_BIT = 4,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWrData,
  input  logic                  cpuWrEnable,
  output logic [DATA_WIDTH-1:0] cpuRdData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWrData,
  output logic                  memWrEnable,
  input  logic [DATA_WIDTH-1:0] memRdData,
  output logic [7:0]            ledOut,
  output logic                  uartTx
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              io_hit;
  logic [7:0]        io_ofs;
  logic              io_wr;
  logic              wr_led;
  logic              wr_uart_data;
  logic              wr_uart_stat;
  logic [7:0]        led_q, led_d;
  logic              ovf_q, ovf_d;
  logic              uart_full;
  logic              uart_empty;
  logic              uart_busy;
  logic [CNT_W-1:0]  uart_count;
  logic [STAT_W-1:0] status;
  logic [DATA_WIDTH-1:0] io_rd_data;

  // Only the page bits are compared; the low byte selects the register
  assign io_hit = (cpuAddr[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8]);
  assign io_ofs = cpuAddr[7:0];
  assign io_wr  = io_hit & cpuWrEnable;

  assign wr_led       = io_wr & (io_ofs == IO_LED_OFS);
  assign wr_uart_data = io_wr & (io_ofs == IO_UART_DATA_OFS);
  assign wr_uart_stat = io_wr & (io_ofs == IO_UART_STAT_OFS);

  // Memory pass-through; IO stores never reach the memory
  assign memAddr     = cpuAddr;
  assign memWrData   = cpuWrData;
  assign memWrEnable = cpuWrEnable & ~io_hit;

  dmem_io_bridge_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_uart_data),
    .pushData (cpuWrData[7:0]),
    .full     (uart_full),
    .empty    (uart_empty),
    .count    (uart_count),
    .busy     (uart_busy),
    .tx       (uartTx)
  );

  // LED and overflow registers. Overflow is judged on the registered full
  // flag, matching the FIFO's own accept rule.
  always_comb begin
    led_d = led_q;
    ovf_d = ovf_q;
    if (wr_led)                   led_d = cpuWrData[7:0];
    if (wr_uart_data && uart_full) ovf_d = 1'b1;
    if (wr_uart_stat)             ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  assign ledOut = led_q;

`ifdef DMEM_IO_BRIDGE_CYCLE_COUNTER_EN
  logic        wr_cycle;
  logic [31:0] cycle_q, cycle_d;

  assign wr_cycle = io_wr & (io_ofs == IO_CYCLE_OFS);

  // A write wins over the increment
  always_comb begin
    cycle_d = wr_cycle ? 32'd0 : cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_d;
  end
`endif

  always_comb begin
    status                                     = '0;
    status[STAT_FULL_BIT]                      = uart_full;
    status[STAT_EMPTY_BIT]                     = uart_empty;
    status[STAT_BUSY_BIT]                      = uart_busy;
    status[STAT_OVF_BIT]                       = ovf_q;
    status[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(uart_count);
  end

  // IO read mux, zero-extended to the data width
  always_comb begin
    io_rd_data = '0;
    case (io_ofs)
      IO_LED_OFS:       io_rd_data = DATA_WIDTH'(led_q);
      IO_UART_STAT_OFS: io_rd_data = DATA_WIDTH'(status);
`ifdef DMEM_IO_BRIDGE_CYCLE_COUNTER_EN
      IO_CYCLE_OFS:     io_rd_data = DATA_WIDTH'(cycle_q);
`endif
      default:          io_rd_data = '0;
    endcase
  end

  assign cpuRdData = io_hit ? io_rd_data : memRdData;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_io_bridge
// Directed bench for dmem_io_bridge at default parameters
// (IO_BASE = 0x3F00, CLKS_PER_BIT = 4, FIFO_DEPTH = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1-2 units after the edge.
// ---------------------------------------------------------------------------
module tb_dmem_io_bridge;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWrData;
  logic          cpuWrEnable;
  logic [DW-1:0] cpuRdData;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWrData;
  logic          memWrEnable;
  logic [DW-1:0] memRdData;
  logic [7:0]    ledOut;
  logic          uartTx;

  int checks = 0;
  int errors = 0;

  dmem_io_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .cpuAddr     (cpuAddr),
    .cpuWrData   (cpuWrData),
    .cpuWrEnable (cpuWrEnable),
    .cpuRdData   (cpuRdData),
    .memAddr     (memAddr),
    .memWrData   (memWrData),
    .memWrEnable (memWrEnable),
    .memRdData   (memRdData),
    .ledOut      (ledOut),
    .uartTx      (uartTx)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a store for one edge, then release the strobe
  task automatic cpu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cpuAddr     = addr;
    cpuWrData   = data;
    cpuWrEnable = 1'b1;
    tick();
    cpuWrEnable = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    cpuAddr     = addr;
    cpuWrEnable = 1'b0;
    #1;
    check(tag, cpuRdData, exp);
  endtask

  // Expected line level at cycle pos (0..39) of an 8N1 frame, 4 clocks/bit
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos < 4)       return 1'b0;
    else if (pos < 36) return b[(pos - 4) / 4];
    else               return 1'b1;
  endfunction

  logic [7:0]  bytes5 [5];
  logic [31:0] c0, c1;

  initial begin
    bytes5 = '{8'h3C, 8'h81, 8'h0F, 8'hF0, 8'h55};

    rst         = 1'b1;
    cpuAddr     = '0;
    cpuWrData   = '0;
    cpuWrEnable = 1'b0;
    memRdData   = 32'hDEADBEEF;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_led", {24'h0, ledOut}, 32'h0);
    check("rst_tx", {31'h0, uartTx}, 32'h1);
    check_read("rst_status", 14'h3F08, 32'h0000_0002);

    // Memory pass-through
    cpuAddr     = 14'h0040;
    cpuWrData   = 32'h12345678;
    cpuWrEnable = 1'b1;
    #1;
    check("mem_we", {31'h0, memWrEnable}, 32'h1);
    check("mem_addr", {18'h0, memAddr}, 32'h0040);
    check("mem_wdata", memWrData, 32'h12345678);
    tick();
    cpuWrEnable = 1'b0;
    check_read("mem_rdata", 14'h0040, 32'hDEADBEEF);

    // LED register
    cpuAddr     = 14'h3F00;
    cpuWrData   = 32'h0000_01A5;
    cpuWrEnable = 1'b1;
    #1;
    check("io_mem_we", {31'h0, memWrEnable}, 32'h0);
    tick();
    cpuWrEnable = 1'b0;
    check("led_out", {24'h0, ledOut}, 32'hA5);
    check_read("led_read", 14'h3F00, 32'h0000_00A5);
    check_read("unmapped_read", 14'h3F10, 32'h0);
    check_read("uart_data_read", 14'h3F04, 32'h0);

    // Single UART frame of 0xA5
    cpu_write(14'h3F04, 32'h0000_00A5);
    check("tx_before_start", {31'h0, uartTx}, 32'h1);
    check_read("status_queued", 14'h3F08, 32'h0000_0010);
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("frame_a5_tx_%0d", k), {31'h0, uartTx}, {31'h0, frame_bit(8'hA5, k)});
      check($sformatf("frame_a5_status_%0d", k), {25'h0, cpuRdData[6:0]}, 32'h0000_0006);
    end
    tick();
    check("tx_after_frame", {31'h0, uartTx}, 32'h1);
    check_read("status_after_frame", 14'h3F08, 32'h0000_0002);

    // Five back-to-back pushes, one overflowing push, overflow clear,
    // then five gapless frames
    for (int i = 0; i < 203; i++) begin
      if (i < 5) begin
        cpuAddr     = 14'h3F04;
        cpuWrData   = {24'h0, bytes5[i]};
        cpuWrEnable = 1'b1;
      end else if (i == 5) begin
        cpuAddr     = 14'h3F04;
        cpuWrData   = 32'h0000_00EE;
        cpuWrEnable = 1'b1;
      end else if (i == 6) begin
        cpuAddr     = 14'h3F08;
        cpuWrData   = 32'hFFFF_FFFF;
        cpuWrEnable = 1'b1;
      end else begin
        cpuWrEnable = 1'b0;
      end
      tick();
      cpuWrEnable = 1'b0;
      cpuAddr     = 14'h3F08;
      #1;
      if (i >= 1) begin
        int k;
        logic exp_tx;
        k      = i - 1;
        exp_tx = (k < 200) ? frame_bit(bytes5[k / 40], k % 40) : 1'b1;
        check($sformatf("burst_tx_%0d", k), {31'h0, uartTx}, {31'h0, exp_tx});
      end
      if (i == 4) check("status_full", cpuRdData, 32'h0000_0045);
      if (i == 5) check("status_overflow", cpuRdData, 32'h0000_004D);
      if (i == 6) check("status_ovf_cleared", cpuRdData, 32'h0000_0045);
    end
    check_read("status_burst_done", 14'h3F08, 32'h0000_0002);

    // Reset in the middle of the data bits
    cpu_write(14'h3F00, 32'h0000_005A);
    check("led_5a", {24'h0, ledOut}, 32'h5A);
    cpu_write(14'h3F04, 32'h0000_0000);
    cpu_write(14'h3F04, 32'h0000_0000);
    repeat (8) tick();
    check("tx_mid_data", {31'h0, uartTx}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tx_after_rst", {31'h0, uartTx}, 32'h1);
    check("led_after_rst", {24'h0, ledOut}, 32'h0);
    check_read("status_after_rst", 14'h3F08, 32'h0000_0002);
    repeat (3) tick();
    check("tx_stays_idle", {31'h0, uartTx}, 32'h1);
    check_read("status_stays_idle", 14'h3F08, 32'h0000_0002);

`ifdef DMEM_IO_BRIDGE_CYCLE_COUNTER_EN
    // Cycle counter
    cpuAddr = 14'h3F0C;
    #1;
    c0 = cpuRdData;
    repeat (10) tick();
    c1 = cpuRdData;
    check("cycle_delta", c1 - c0, 32'd10);
    cpu_write(14'h3F0C, 32'h0000_1234);
    check_read("cycle_cleared", 14'h3F0C, 32'd0);
    tick();
    check_read("cycle_after_clear", 14'h3F0C, 32'd1);
`else
    // No counter: offset 0x0C reads zero and stores are swallowed
    memRdData   = 32'hCAFEF00D;
    cpuAddr     = 14'h3F0C;
    cpuWrData   = 32'h0000_FFFF;
    cpuWrEnable = 1'b1;
    #1;
    check("cycle_wr_mem_we", {31'h0, memWrEnable}, 32'h0);
    tick();
    cpuWrEnable = 1'b0;
    c0 = 32'h0;
    c1 = 32'h0;
    check_read("cycle_absent_read", 14'h3F0C, c0 | c1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
